apb_cmd_master: RTL

APB initiator that converts a simple valid/ready command stream into single APB3 transfers and returns read data and error status on a valid/ready response port. It drives the slave-side APB bus of peripherals such as the advanced timer, replacing hand-written bus tasks in benches and serving as the register-access engine for on-chip sequencers. One transfer is outstanding at a time. A programmable PREADY timeout prevents a hung slave from stalling the initiator.

---
 rtl/apb_cmd_master_pkg.sv | 19 +
 rtl/apb_cmd_master.sv | 119 +++++++++++
 2 files changed

// File: rtl/apb_cmd_master_pkg.sv
// Shared types and constants for the APB command master.
package apb_cmd_master_pkg;

  localparam int unsigned APB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic [APB_DATA_WIDTH-1:0] rdata;
    logic                      err;
    logic                      timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_cmd_master.sv
// APB3 initiator: one valid/ready command becomes one APB transfer,
// with the result returned on a valid/ready response port.
module apb_cmd_master
  import apb_cmd_master_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_write_i,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [APB_DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      rsp_timeout_o,
  output logic                      busy_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [APB_DATA_WIDTH-1:0] PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [APB_DATA_WIDTH-1:0] PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  // Last ACCESS cycle index allowed before the abort; unused when disabled.
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [APB_ADDR_WIDTH-1:0] WORD_MASK = ~APB_ADDR_WIDTH'(3);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  apb_rsp_t           rsp_q;

  assign rsp_rdata_o   = rsp_q.rdata;
  assign rsp_err_o     = rsp_q.err;
  assign rsp_timeout_o = rsp_q.timeout;

  // Transfer sequencer: state, APB drive, response capture and wait counter.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_q       <= '0;
      cmd_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PWRITE      <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready_o <= 1'b1;
          if (cmd_valid_i && cmd_ready_o) begin
            PWRITE      <= cmd_write_i;
            PADDR       <= cmd_addr_i & WORD_MASK;
            PWDATA      <= cmd_wdata_i;
            cnt_q       <= '0;
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            PSEL        <= 1'b1;
            PENABLE     <= 1'b0;
            state_q     <= SETUP;
          end
        end

        SETUP: begin
          PENABLE <= 1'b1;
          state_q <= ACCESS;
        end

        ACCESS: begin
          // Completion is checked first so a late PREADY beats the timeout.
          if (PREADY) begin
            rsp_q.rdata   <= PWRITE ? '0 : PRDATA;
            rsp_q.err     <= PSLVERR;
            rsp_q.timeout <= 1'b0;
            PSEL          <= 1'b0;
            PENABLE       <= 1'b0;
            rsp_valid_o   <= 1'b1;
            state_q       <= RESP;
          end else if (TIMEOUT_EN && (cnt_q == TERM_CNT)) begin
            rsp_q.rdata   <= '0;
            rsp_q.err     <= 1'b1;
            rsp_q.timeout <= 1'b1;
            PSEL          <= 1'b0;
            PENABLE       <= 1'b0;
            rsp_valid_o   <= 1'b1;
            state_q       <= RESP;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            cmd_ready_o <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
